// File: rtl/vga_pkg.sv
// Shared VGA framebuffer constants, fill-engine state type and the
// framebuffer address helper used by the arbiter and the fill engine.
package vga_pkg;

  localparam logic [10:0] H_ACTIVE = 11'd640;
  localparam logic [10:0] H_TOTAL  = 11'd800;
  localparam logic [9:0]  V_ACTIVE = 10'd480;
  localparam logic [9:0]  V_TOTAL  = 10'd525;
  localparam logic [7:0]  FB_W     = 8'd160;
  localparam logic [6:0]  FB_H     = 7'd120;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // y*160 + x built from shifts; the largest valid address is 19199.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
    return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
  endfunction

endpackage

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: validates a start request, then walks the
// rectangle in raster order, issuing one write per granted free slot.
module vga_rect_fill
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [7:0]        i_x0,
  input  logic [7:0]        i_x1,
  input  logic [6:0]        i_y0,
  input  logic [6:0]        i_y1,
  input  logic [DATA_W-1:0] i_color,
  input  logic              i_grant,
  output logic              o_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  fill_state_t       r_state;
  fill_state_t       w_next;
  logic [7:0]        r_x;
  logic [7:0]        r_x0;
  logic [7:0]        r_x1;
  logic [6:0]        r_y;
  logic [6:0]        r_y1;
  logic [DATA_W-1:0] r_color;
  logic              r_err;
  logic              w_start_ok;
  logic              w_accept;
  logic              w_last;

  assign w_start_ok = (i_x0 <= i_x1) && (i_x1 < FB_W) && (i_y0 <= i_y1) && (i_y1 < FB_H);
  assign w_accept   = (r_state == IDLE) && i_start && w_start_ok;
  assign w_last     = (r_x == r_x1) && (r_y == r_y1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == IDLE) && i_start && !w_start_ok;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = FILL;
      FILL:    if (i_grant && w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bounds and cursor are pure data: only meaningful while FILL is active.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_x     <= i_x0;
      r_y     <= i_y0;
      r_x0    <= i_x0;
      r_x1    <= i_x1;
      r_y1    <= i_y1;
      r_color <= i_color;
    end else if ((r_state == FILL) && i_grant) begin
      if (r_x == r_x1) begin
        r_x <= r_x0;
        r_y <= r_y + 7'd1;
      end else begin
        r_x <= r_x + 8'd1;
      end
    end
  end

  assign o_req  = (r_state == FILL);
  assign o_addr = fb_addr(r_x, r_y);
  assign o_data = r_color;
  assign o_busy = (r_state != IDLE);
  assign o_done = (r_state == DONE);
  assign o_err  = r_err;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display scanout owns every fourth cycle
// in active video, remaining cycles go to the fill engine, then the host.
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  output logic [DATA_W-1:0] rgb,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_x,
  input  logic [6:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rect_start,
  input  logic [7:0]        rect_x0,
  input  logic [7:0]        rect_x1,
  input  logic [6:0]        rect_y0,
  input  logic [6:0]        rect_y1,
  input  logic [DATA_W-1:0] rect_color,
  output logic              rect_busy,
  output logic              rect_done,
  output logic              rect_err
);

  logic [10:0]       w_nh;
  logic [9:0]        w_nv;
  logic              w_slot_p0;
  logic              w_free;
  logic [ADDR_W-1:0] w_disp_addr;
  logic              r_vld_p1;
  logic [DATA_W-1:0] r_pix_p2;
  logic              w_fill_req;
  logic              w_fill_grant;
  logic [ADDR_W-1:0] w_fill_addr;
  logic [DATA_W-1:0] w_fill_data;
  logic              w_host_fire;
  logic              w_host_in_range;

  // Slot p0: look two pixels ahead so the group is ready when it starts.
  assign w_nh = (hcount >= H_TOTAL - 11'd2) ? hcount - (H_TOTAL - 11'd2) : hcount + 11'd2;
  assign w_nv = (hcount < H_TOTAL - 11'd2) ? vcount
              : ((vcount == V_TOTAL - 10'd1) ? 10'd0 : vcount + 10'd1);
  assign w_slot_p0   = (hcount[1:0] == 2'd2) && (w_nh < H_ACTIVE) && (w_nv < V_ACTIVE);
  assign w_disp_addr = fb_addr(w_nh[9:2], w_nv[8:2]);
  assign w_free      = !w_slot_p0;

  // p1: read data returns; p2: pixel register holds the current group.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_pix_p2 <= '0;
    end else begin
      r_vld_p1 <= w_slot_p0;
      if (r_vld_p1) r_pix_p2 <= ram_rdata;
    end
  end

  assign rgb = ((hcount < H_ACTIVE) && (vcount < V_ACTIVE)) ? r_pix_p2 : '0;

  vga_rect_fill u_fill (
    .clk     (clk),
    .reset   (reset),
    .i_start (rect_start),
    .i_x0    (rect_x0),
    .i_x1    (rect_x1),
    .i_y0    (rect_y0),
    .i_y1    (rect_y1),
    .i_color (rect_color),
    .i_grant (w_fill_grant),
    .o_req   (w_fill_req),
    .o_addr  (w_fill_addr),
    .o_data  (w_fill_data),
    .o_busy  (rect_busy),
    .o_done  (rect_done),
    .o_err   (rect_err)
  );

  assign w_fill_grant    = w_free && w_fill_req;
  assign wr_ready        = w_free && !rect_busy;
  assign w_host_fire     = wr_valid && wr_ready;
  assign w_host_in_range = (wr_x < FB_W) && (wr_y < FB_H);

  always_comb begin
    ram_addr  = w_disp_addr;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (w_slot_p0) begin
      ram_addr = w_disp_addr;
    end else if (w_fill_grant) begin
      ram_addr  = w_fill_addr;
      ram_we    = 1'b1;
      ram_wdata = w_fill_data;
    end else if (w_host_fire) begin
      // Out-of-range host pixels complete the handshake but never write.
      ram_addr  = fb_addr(wr_x, wr_y);
      ram_we    = w_host_in_range;
      ram_wdata = wr_data;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: RAM model, timing generator and a
// frame-position model of display slots, pixels and write ordering.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [7:0]  rgb;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [7:0]  wr_data;
  logic        rect_start;
  logic [7:0]  rect_x0, rect_x1;
  logic [6:0]  rect_y0, rect_y1;
  logic [7:0]  rect_color;
  logic        rect_busy, rect_done, rect_err;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .rgb(rgb),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .rect_start(rect_start), .rect_x0(rect_x0), .rect_x1(rect_x1),
    .rect_y0(rect_y0), .rect_y1(rect_y1), .rect_color(rect_color),
    .rect_busy(rect_busy), .rect_done(rect_done), .rect_err(rect_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (h=%0d v=%0d t=%0t)", nm, act, exp, hcount, vcount, $time);
    end
  endtask

  // Framebuffer RAM: synchronous read, data valid the cycle after the address.
  logic [7:0]  mem [0:19199];
  logic        pre_en;
  logic [14:0] pre_addr;
  logic [7:0]  pre_data;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_we && ram_addr < 15'd19200) mem[ram_addr] <= ram_wdata;
    ram_rdata <= (ram_addr < 15'd19200) ? mem[ram_addr] : 8'h00;
  end

  // Expected framebuffer contents for every address the bench cares about.
  int shadow [int];

  // Frame-position model: a slot reads the group that starts two pixels later.
  function automatic bit m_slot(input int h, input int v);
    int p, nh, nv;
    p  = (v * 800 + h + 2) % (800 * 525);
    nh = p % 800;
    nv = p / 800;
    return (h % 4 == 2) && (nh < 640) && (nv < 480);
  endfunction

  function automatic int m_addr(input int h, input int v);
    int p;
    p = (v * 800 + h + 2) % (800 * 525);
    return ((p / 800) / 4) * 160 + (p % 800) / 4;
  endfunction

  function automatic int exp_rgb(input int h, input int v);
    if (h < 640 && v < 480) return shadow[(v / 4) * 160 + h / 4];
    return 0;
  endfunction

  typedef struct { int a; int d; } wr_t;
  wr_t wlog[$];
  int  done_cnt = 0;
  int  err_cnt  = 0;

  always @(negedge clk) begin
    if (ram_we) wlog.push_back('{int'(ram_addr), int'(ram_wdata)});
    if (rect_done) done_cnt++;
    if (rect_err) err_cnt++;
    if (m_slot(int'(hcount), int'(vcount))) begin
      chk("slot_we", int'(ram_we), 0);
      chk("slot_addr", int'(ram_addr), m_addr(int'(hcount), int'(vcount)));
    end
  end

  task automatic adv();
    if (hcount == 11'd799) begin
      hcount = 11'd0;
      vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount = hcount + 11'd1;
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    adv();
  endtask

  task automatic pulse(input int x0, input int x1, input int y0, input int y1, input int c);
    rect_x0    = 8'(x0);
    rect_x1    = 8'(x1);
    rect_y0    = 7'(y0);
    rect_y1    = 7'(y1);
    rect_color = 8'(c);
    rect_start = 1'b1;
    next();
    rect_start = 1'b0;
  endtask

  task automatic fill_wait(input int maxc, output bit got);
    got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      #1;
      if (rect_done) begin
        got = 1'b1;
        break;
      end
      next();
    end
  endtask

  typedef struct { int h; int v; int slot; int addr; } vec_t;
  typedef struct { int x0; int x1; int y0; int y1; } bad_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [15];
    bad_t bad [4];
    wr_t  exp_q [$];
    bit   got;
    int   n, rdy_bad, acc_h;
    int   rx, ry, rd;
    bit   rv, rdy;

    tbl[0]  = '{798, 524, 1, 0};
    tbl[1]  = '{2,   0,   1, 1};
    tbl[2]  = '{0,   0,   0, 0};
    tbl[3]  = '{634, 0,   1, 159};
    tbl[4]  = '{638, 0,   0, 0};
    tbl[5]  = '{798, 0,   1, 0};
    tbl[6]  = '{798, 3,   1, 160};
    tbl[7]  = '{798, 478, 1, 19040};
    tbl[8]  = '{798, 479, 0, 0};
    tbl[9]  = '{2,   479, 1, 19041};
    tbl[10] = '{2,   480, 0, 0};
    tbl[11] = '{798, 523, 0, 0};
    tbl[12] = '{1,   0,   0, 0};
    tbl[13] = '{3,   0,   0, 0};
    tbl[14] = '{6,   100, 1, 4002};
    bad[0]  = '{80, 40,  0,  0};
    bad[1]  = '{0,  160, 0,  0};
    bad[2]  = '{0,  0,   10, 5};
    bad[3]  = '{0,  0,   0,  120};

    reset = 1'b1; hcount = 11'd0; vcount = 10'd0;
    wr_valid = 1'b0; wr_x = 8'd0; wr_y = 7'd0; wr_data = 8'd0;
    rect_start = 1'b0; rect_x0 = 8'd0; rect_x1 = 8'd0; rect_y0 = 7'd0; rect_y1 = 7'd0;
    rect_color = 8'd0; pre_en = 1'b0; pre_addr = 15'd0; pre_data = 8'd0;
    #2;
    chk("reset_rgb", int'(rgb), 0);
    chk("reset_busy", int'(rect_busy), 0);
    chk("reset_ready", int'(wr_ready), 1);
    chk("reset_done", int'(rect_done), 0);
    chk("reset_err", int'(rect_err), 0);
    chk("reset_we", int'(ram_we), 0);

    // Preload rows 0, 1 and 119 through the bench-side RAM port.
    for (int i = 0; i < 480; i++) begin
      @(posedge clk); #1;
      pre_en   = 1'b1;
      pre_addr = 15'((i < 320) ? i : 19040 + (i - 320));
      pre_data = (i == 0) ? 8'hE0 : (i == 1) ? 8'h1C : 8'($urandom);
      shadow[int'(pre_addr)] = int'(pre_data);
    end
    @(posedge clk); #1;
    pre_en = 1'b0;
    reset  = 1'b0;

    // Slot decode vectors.
    foreach (tbl[i]) begin
      hcount = 11'(tbl[i].h);
      vcount = 10'(tbl[i].v);
      #1;
      chk($sformatf("tbl%0d_ready", i), int'(wr_ready), 1 - tbl[i].slot);
      chk($sformatf("tbl%0d_we", i), int'(ram_we), 0);
      if (tbl[i].slot == 1) chk($sformatf("tbl%0d_addr", i), int'(ram_addr), tbl[i].addr);
    end

    // Scanout of the first lines of a frame.
    next();
    hcount = 11'd798; vcount = 10'd524;
    #1;
    chk("first_read_addr", int'(ram_addr), 0);
    for (int i = 0; i < 4002; i++) begin
      next(); #1;
      if (hcount == 11'd2 && vcount == 10'd0) chk("second_read_addr", int'(ram_addr), 1);
      if (hcount == 11'd0 && vcount == 10'd0) chk("rgb_px0", int'(rgb), 8'hE0);
      if (hcount == 11'd4 && vcount == 10'd0) chk("rgb_px4", int'(rgb), 8'h1C);
      chk("rgb_top", int'(rgb), exp_rgb(int'(hcount), int'(vcount)));
    end
    next();
    hcount = 11'd790; vcount = 10'd478;
    #1;
    chk("rgb_hblank", int'(rgb), 0);
    for (int i = 0; i < 840; i++) begin
      next(); #1;
      chk("rgb_bottom", int'(rgb), exp_rgb(int'(hcount), int'(vcount)));
    end

    // Host write offered in a display slot, accepted in the next free cycle.
    next();
    hcount = 11'd2; vcount = 10'd20;
    wlog.delete();
    wr_valid = 1'b1; wr_x = 8'd10; wr_y = 7'd5; wr_data = 8'h03;
    #1;
    chk("host_ready_in_slot", int'(wr_ready), 0);
    acc_h = -1;
    for (int i = 0; i < 8; i++) begin
      next(); #1;
      if (wr_ready) begin
        acc_h = int'(hcount);
        next();
        wr_valid = 1'b0;
        break;
      end
    end
    wr_valid = 1'b0;
    chk("host_accept_h", acc_h, 3);
    for (int i = 0; i < 8; i++) next();
    #1;
    chk("host_write_count", wlog.size(), 1);
    if (wlog.size() > 0) begin
      chk("host_write_addr", wlog[0].a, 810);
      chk("host_write_data", wlog[0].d, 8'h03);
    end
    shadow[810] = 8'h03;

    // Fill with a simultaneous host write, and a start ignored mid-fill.
    next();
    hcount = 11'd0; vcount = 10'd30;
    wlog.delete(); done_cnt = 0;
    wr_valid = 1'b1; wr_x = 8'd1; wr_y = 7'd1; wr_data = 8'h55;
    rect_x0 = 8'd25; rect_x1 = 8'd75; rect_y0 = 7'd25; rect_y1 = 7'd50;
    rect_color = 8'hE0; rect_start = 1'b1;
    #1;
    chk("simul_ready", int'(wr_ready), 1);
    next();
    rect_start = 1'b0;
    wr_x = 8'd2; wr_y = 7'd2; wr_data = 8'h66;
    #1;
    chk("fill_busy", int'(rect_busy), 1);
    got = 1'b0; rdy_bad = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i > 0) #1;
      if (rect_busy && wr_ready) rdy_bad++;
      if (rect_done) begin
        got = 1'b1;
        wr_valid = 1'b0;
        break;
      end
      if (i == 100) begin
        rect_x0 = 8'd0; rect_x1 = 8'd3; rect_y0 = 7'd0; rect_y1 = 7'd3;
        rect_color = 8'h11; rect_start = 1'b1;
      end
      next();
      rect_start = 1'b0;
    end
    wr_valid = 1'b0;
    chk("fill_done_seen", int'(got), 1);
    chk("fill_host_ready_while_busy", rdy_bad, 0);
    for (int i = 0; i < 4; i++) next();
    #1;
    chk("fill_done_pulses", done_cnt, 1);
    chk("fill_busy_after", int'(rect_busy), 0);
    exp_q.delete();
    exp_q.push_back('{161, 8'h55});
    for (int y = 25; y <= 50; y++)
      for (int x = 25; x <= 75; x++) exp_q.push_back('{y * 160 + x, 8'hE0});
    chk("fill_write_count", wlog.size(), exp_q.size());
    n = (wlog.size() < exp_q.size()) ? wlog.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("fill_addr", wlog[i].a, exp_q[i].a);
      chk("fill_data", wlog[i].d, exp_q[i].d);
    end
    foreach (exp_q[i]) shadow[exp_q[i].a] = exp_q[i].d;

    // Rejected starts.
    wlog.delete(); err_cnt = 0;
    foreach (bad[i]) begin
      pulse(bad[i].x0, bad[i].x1, bad[i].y0, bad[i].y1, 8'hAA);
      #1;
      chk($sformatf("bad%0d_err", i), int'(rect_err), 1);
      chk($sformatf("bad%0d_busy", i), int'(rect_busy), 0);
      next(); #1;
      chk($sformatf("bad%0d_err_clear", i), int'(rect_err), 0);
    end
    chk("bad_err_pulses", err_cnt, 4);
    chk("bad_no_writes", wlog.size(), 0);

    // Single pixel at the far corner of the framebuffer.
    wlog.delete();
    pulse(159, 159, 119, 119, 8'h5A);
    fill_wait(100, got);
    chk("corner_done", int'(got), 1);
    next(); #1;
    chk("corner_write_count", wlog.size(), 1);
    if (wlog.size() > 0) begin
      chk("corner_addr", wlog[0].a, 19199);
      chk("corner_data", wlog[0].d, 8'h5A);
    end
    shadow[19199] = 8'h5A;

    // Reset in the middle of a full-screen fill.
    wlog.delete();
    pulse(0, 159, 0, 119, 8'h33);
    for (int i = 0; i < 200; i++) next();
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", int'(rect_busy), 0);
    chk("abort_we", int'(ram_we), 0);
    chk("abort_done", int'(rect_done), 0);
    next(); next(); #1;
    reset = 1'b0;
    n = wlog.size();
    chk("abort_wrote_some", int'(n > 0), 1);
    for (int i = 0; i < n; i++) begin
      chk("abort_prefix_addr", wlog[i].a, i);
      chk("abort_prefix_data", wlog[i].d, 8'h33);
      shadow[i] = 8'h33;
    end
    if (n > 0) chk("abort_mem_kept", int'(mem[n - 1]), 8'h33);
    next();
    wlog.delete(); done_cnt = 0;
    pulse(10, 11, 100, 101, 8'h77);
    #1;
    chk("restart_busy", int'(rect_busy), 1);
    fill_wait(100, got);
    chk("restart_done", int'(got), 1);
    for (int i = 0; i < 3; i++) next();
    #1;
    chk("restart_done_pulses", done_cnt, 1);
    exp_q.delete();
    exp_q.push_back('{16010, 8'h77});
    exp_q.push_back('{16011, 8'h77});
    exp_q.push_back('{16170, 8'h77});
    exp_q.push_back('{16171, 8'h77});
    chk("restart_write_count", wlog.size(), 4);
    n = (wlog.size() < 4) ? wlog.size() : 4;
    for (int i = 0; i < n; i++) begin
      chk("restart_addr", wlog[i].a, exp_q[i].a);
      chk("restart_data", wlog[i].d, exp_q[i].d);
    end
    foreach (exp_q[i]) shadow[exp_q[i].a] = exp_q[i].d;

    // Random host traffic across the end of active video.
    next();
    hcount = 11'd600; vcount = 10'd477;
    for (int i = 0; i < 3000; i++) begin
      if (i > 0) next();
      rv = ($urandom_range(0, 9) < 7);
      rx = int'($urandom_range(0, 175));
      ry = int'($urandom_range(0, 127));
      rd = int'($urandom_range(0, 255));
      wr_valid = rv; wr_x = 8'(rx); wr_y = 7'(ry); wr_data = 8'(rd);
      #1;
      rdy = !m_slot(int'(hcount), int'(vcount));
      chk("rand_ready", int'(wr_ready), int'(rdy));
      if (rv && rdy && rx < 160 && ry < 120) begin
        chk("rand_we", int'(ram_we), 1);
        chk("rand_addr", int'(ram_addr), ry * 160 + rx);
        chk("rand_data", int'(ram_wdata), rd);
        shadow[ry * 160 + rx] = rd;
      end else if (rdy) begin
        chk("rand_no_we", int'(ram_we), 0);
      end
    end
    next();
    wr_valid = 1'b0;
    next(); next(); #1;

    foreach (shadow[k]) chk($sformatf("mem[%0d]", k), int'(mem[k]), shadow[k]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Owns the single-port 160x120x8bpp framebuffer RAM behind the 640x480 VGA timing generator.
- Three users share the RAM:
  - display scanout, fixed priority, using 4x pixel replication;
  - a rectangle-fill engine;
  - a host pixel-write port with valid/ready handshake.
- Produces the 8-bit RGB332 pixel aligned to the timing generator's hcount/vcount.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines
- H_TOTAL, 800, clocks per line (hcount wraps at H_TOTAL-1)
- V_TOTAL, 525, lines per frame
- FB_W, 160, framebuffer width (H_ACTIVE/4)
- FB_H, 120, framebuffer height (V_ACTIVE/4)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- hcount  in  11  horizontal count from timing generator, registered upstream
- vcount  in  10  vertical count from timing generator, registered upstream
- rgb  out  8  pixel {r[2:0],g[2:0],b[1:0]}, aligned to current hcount/vcount
- ram_addr  out  15  framebuffer address, y*160+x
- ram_we  out  1  write enable
- ram_wdata  out  8  write data
- ram_rdata  in  8  read data, valid the cycle after address presented
- wr_valid  in  1  host write request
- wr_ready  out  1  host write accepted this cycle when wr_valid=1
- wr_x  in  8  host pixel x, 0..159
- wr_y  in  7  host pixel y, 0..119
- wr_data  in  8  host pixel colour
- rect_start  in  1  one-cycle pulse, start rectangle fill
- rect_x0, rect_x1  in  8  inclusive x bounds
- rect_y0, rect_y1  in  7  inclusive y bounds
- rect_color  in  8  fill colour
- rect_busy  out  1  fill engine active
- rect_done  out  1  one-cycle pulse after last fill write
- rect_err  out  1  one-cycle pulse, start rejected

Behaviour:
- Reset (async) values:
  - rgb=0, rect_busy=0, rect_done=0, rect_err=0;
  - engine state IDLE;
  - pixel register = 0.
- RAM outputs and wr_ready are combinational from the registered state plus current hcount/vcount/wr_valid.
- Display slot:
  - Occurs when hcount[1:0]==2 and next group is visible.
  - Next column nh=(hcount+2) mod H_TOTAL; next line nv = vcount if hcount<H_TOTAL-2, else (vcount+1) mod V_TOTAL.
  - Slot fires iff nh<H_ACTIVE and nv<V_ACTIVE.
  - Read address = (nv>>2)*160 + (nh>>2), with ram_we=0.
- Pixel register:
  - Loads ram_rdata on the clock edge ending the cycle after a display slot.
  - It therefore holds group g during hcount 4g..4g+3.
- rgb output:
  - rgb = pixel register when hcount<H_ACTIVE and vcount<V_ACTIVE; otherwise 0.
  - Zero latency relative to the hcount/vcount inputs.
- Free slots: every cycle that is not a display slot. Priority within a free slot: fill engine > host.
- Host port:
  - wr_ready = free slot and engine IDLE; independent of wr_valid.
  - A write occurs when wr_valid & wr_ready: ram_we=1, addr=wr_y*160+wr_x, wdata=wr_data.
  - Out-of-range wr_x>=160 or wr_y>=120: accepted and dropped, ram_we=0.
- Fill engine FSM:
  - IDLE: on rect_start, validate x0<=x1<=159 and y0<=y1<=119.
    - Invalid: rect_err pulse next cycle, stay IDLE.
    - Valid: latch bounds and colour; cursor=(x0,y0); go to FILL.
  - FILL:
    - Each free slot writes colour at cursor, then advances.
    - Advance is raster order: x++; at x1, x=x0 and y++.
    - Write at (x1,y1) goes to DONE.
  - DONE: rect_done=1 for one cycle, then IDLE.
  - rect_busy=1 in FILL and DONE.
  - rect_start outside IDLE is ignored.
- Address arithmetic: y*160 = (y<<7)+(y<<5); 15-bit result, no overflow for valid coordinates.
- Reset mid-fill: immediate abort to IDLE; already-written pixels remain.
- Simultaneous rect_start and wr_valid in IDLE: the host write completes that cycle if wr_ready=1; the engine starts next cycle.

Decomposition:
- Shared package vga_pkg: H_ACTIVE/V_ACTIVE/H_TOTAL/V_TOTAL, FB_W/FB_H, fill-state enum (IDLE, FILL, DONE), and an fb_addr(x,y) function.
- One natural sub-module, vga_rect_fill: the fill FSM and cursor, exposing req/addr/data and grant.
- Slot decode and muxing stay in the top.

Test Plan:
- Reset with hcount=0, vcount=0 → rgb=0, rect_busy=0, wr_ready=1 (cycle hcount=0 is a free slot).
- Preload ram[0]=8'hE0 and ram[1]=8'h1C; run from hcount=798 on vcount=524:
  - read of addr 0 at hcount=798 and addr 1 at hcount=2;
  - rgb=E0 for hcount 0..3 and rgb=1C for hcount 4..7 on line 0.
- Hold wr_valid=1 with (10,5,8'h03) through active video → ram_we never in a display slot; exactly one write at addr 810; wr_ready=0 at hcount[1:0]==2 in active area.
- rect_start with (25,25)-(75,50) colour 8'hE0 → writes the 51x26=1326 addresses in raster order; rect_done once; host wr_ready=0 throughout.
- rect_start with x0=80, x1=40 → rect_err pulse, no RAM writes; rect_start during FILL → ignored, bounds unchanged.
- Assert reset mid-fill → rect_busy=0 asynchronously, ram_we=0, next valid rect_start accepted.
